// File: rtl/sprite_pkg.sv
// Shared constants and elaboration helpers for the sprite ROM arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sprite_pkg;

    localparam logic [15:0] SPRITE_KEY_COLOR = 16'hF81F;

    // Ceiling log2. Returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel-index width. Never zero, so a single channel still has a 1-bit index.
    function automatic int ch_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/sprite_rom_core.sv
// Single-port sprite ROM, DEPTH x DATA_W; contents are supplied by the environment.
// Latency: 1 cycle, registered output; output holds while rd_en is low.
// Backpressure: none; a read is accepted on every cycle with rd_en high.
module sprite_rom_core #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 11,
    parameter int    DEPTH     = 1600,
    parameter string INIT_FILE = "../mif/shell.mif"
) (
    input  logic              clka,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_dat_d;
    logic [DATA_W-1:0] rd_dat_q;

    // Read mux: fetch on enable, otherwise keep the last word; addresses past DEPTH read 0.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            if ({{(32-ADDR_W){1'b0}}, rd_addr} < DEPTH) begin
                rd_dat_d = mem[rd_addr];
            end else begin
                rd_dat_d = '0;
            end
        end
    end

    // Output register (ROM data is not reset).
    always_ff @(posedge clka) begin
        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/sprite_rom_arb.sv
// Round-robin arbiter giving NCH channels (x,y) pixel reads from a sprite ROM; SPRITE_ROM_KEY_EN adds key-colour opacity.
// Latency: fixed 2 cycles from transfer to rsp_valid (address register, registered ROM).
// Backpressure: one grant per cycle via req_ready; responses cannot be stalled.
module sprite_rom_arb
    import sprite_pkg::*;
#(
    parameter int              DATA_W    = 16,
    parameter int              ADDR_W    = 11,
    parameter int              DEPTH     = 1600,
    parameter int              SPR_W     = 40,
    parameter int              SPR_H     = 40,
    parameter int              COORD_W   = 6,
    parameter int              NCH       = 2,
    parameter string           INIT_FILE = "../mif/shell.mif",
    parameter logic [DATA_W-1:0] KEY_COLOR = DATA_W'(SPRITE_KEY_COLOR)
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic [NCH-1:0]           req_valid,
    input  logic [NCH*COORD_W-1:0]   req_x,
    input  logic [NCH*COORD_W-1:0]   req_y,
    output logic [NCH-1:0]           req_ready,
    output logic                     rsp_valid,
    output logic [ch_w(NCH)-1:0]     rsp_ch,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_oob,
    output logic                     rsp_opaque
);

    localparam int CH_W = ch_w(NCH);
    localparam int AW2  = ADDR_W + COORD_W;

    generate
        if (SPR_W * SPR_H > DEPTH)         begin : g_chk_size  $error("sprite larger than ROM"); end
        if (DEPTH > (1 << ADDR_W))         begin : g_chk_depth $error("DEPTH exceeds ADDR_W range"); end
        if (NCH < 1)                       begin : g_chk_nch   $error("NCH must be at least 1"); end
        if ($bits(KEY_COLOR) != DATA_W)    begin : g_chk_key   $error("KEY_COLOR width mismatch"); end
    endgenerate

    logic              fire;
    logic [CH_W-1:0]   gnt_idx;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic [AW2-1:0]    lin_addr;
    logic              req_oob;
    int                idx;

    logic [CH_W-1:0]   ptr_d,    ptr_q;
    logic              s1_vld_d, s1_vld_q;
    logic [CH_W-1:0]   s1_ch_d,  s1_ch_q;
    logic              s1_oob_d, s1_oob_q;
    logic [ADDR_W-1:0] addr_d,   addr_q;
    logic              s2_vld_d, s2_vld_q;
    logic [CH_W-1:0]   s2_ch_d,  s2_ch_q;
    logic              s2_oob_d, s2_oob_q;
    logic              s2_inr_d, s2_inr_q;
    logic [DATA_W-1:0] rom_dat;

    // Round-robin grant: first valid channel at or after the pointer; nothing granted in reset.
    always_comb begin
        req_ready = '0;
        fire      = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        if (!rsta) begin
            for (int k = 0; k < NCH; k++) begin
                idx = (int'(ptr_q) + k) % NCH;
                if (!fire && req_valid[idx]) begin
                    fire           = 1'b1;
                    gnt_idx        = CH_W'(idx);
                    req_ready[idx] = 1'b1;
                end
            end
        end
    end

    // Address generation for the granted channel; out-of-range coordinates map to address 0.
    always_comb begin
        sel_x    = req_x[int'(gnt_idx)*COORD_W +: COORD_W];
        sel_y    = req_y[int'(gnt_idx)*COORD_W +: COORD_W];
        req_oob  = (int'(sel_x) >= SPR_W) || (int'(sel_y) >= SPR_H);
        lin_addr = AW2'(sel_y) * AW2'(SPR_W) + AW2'(sel_x);
    end

    // Next-state for pointer and both pipeline stages; side-band fields hold between responses.
    always_comb begin
        ptr_d    = ptr_q;
        s1_vld_d = fire;
        s1_ch_d  = s1_ch_q;
        s1_oob_d = s1_oob_q;
        addr_d   = addr_q;
        s2_vld_d = s1_vld_q;
        s2_ch_d  = s2_ch_q;
        s2_oob_d = s2_oob_q;
        s2_inr_d = s2_inr_q;
        if (fire) begin
            ptr_d    = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
            s1_ch_d  = gnt_idx;
            s1_oob_d = req_oob;
            addr_d   = req_oob ? '0 : lin_addr[ADDR_W-1:0];
        end
        if (s1_vld_q) begin
            s2_ch_d  = s1_ch_q;
            s2_oob_d = s1_oob_q;
            s2_inr_d = ~s1_oob_q;
        end
    end

    // Pipeline and pointer registers; reset drops anything in flight.
    always_ff @(posedge clka) begin
        if (rsta) begin
            ptr_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_ch_q  <= '0;
            s1_oob_q <= 1'b0;
            addr_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_ch_q  <= '0;
            s2_oob_q <= 1'b0;
            s2_inr_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            s1_vld_q <= s1_vld_d;
            s1_ch_q  <= s1_ch_d;
            s1_oob_q <= s1_oob_d;
            addr_q   <= addr_d;
            s2_vld_q <= s2_vld_d;
            s2_ch_q  <= s2_ch_d;
            s2_oob_q <= s2_oob_d;
            s2_inr_q <= s2_inr_d;
        end
    end

    sprite_rom_core #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clka    (clka),
        .rd_en   (s1_vld_q),
        .rd_addr (addr_q),
        .rd_dat  (rom_dat)
    );

    // In-range flag gates the ROM word, so oob responses and the reset state read as 0.
    assign rsp_valid = s2_vld_q;
    assign rsp_ch    = s2_ch_q;
    assign rsp_oob   = s2_oob_q;
    assign rsp_data  = s2_inr_q ? rom_dat : '0;
`ifdef SPRITE_ROM_KEY_EN
    assign rsp_opaque = s2_inr_q && (rom_dat != KEY_COLOR);
`else
    assign rsp_opaque = s2_inr_q;
`endif

endmodule

// File: tb/tb_sprite_rom_arb.sv
// Directed bench for sprite_rom_arb: reset, single reads, round-robin, oob, key colour, mid-flight reset.
// Latency: expects responses exactly 2 cycles after each transfer.
// Backpressure: none exercised beyond the arbiter's own one-grant-per-cycle.
module tb_sprite_rom_arb;

    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [11:0] req_x = '0;
    logic [11:0] req_y = '0;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [0:0]  rsp_ch;
    logic [15:0] rsp_data;
    logic        rsp_oob;
    logic        rsp_opaque;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clka = ~clka;

    sprite_rom_arb #(
        .INIT_FILE ("")
    ) dut (
        .clka       (clka),
        .rsta       (rsta),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ch     (rsp_ch),
        .rsp_data   (rsp_data),
        .rsp_oob    (rsp_oob),
        .rsp_opaque (rsp_opaque)
    );

    // ROM image placed by the bench: word 0 is the key colour, others A000+index.
    function automatic logic [15:0] rom_word(input int a);
        return (a == 0) ? 16'hF81F : 16'hA000 + 16'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clka); #1;
        rsta      = 1'b1;
        req_valid = 2'b11;
        @(negedge clka);
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        @(posedge clka); #1;
        req_valid = 2'b00;
        rsta      = 1'b0;
    endtask

    // One request on one channel; checks grant, 2-cycle latency and the response fields.
    task automatic single(input string tag, input int ch, input int x, input int y,
                          input logic [15:0] exp_dat, input logic exp_oob, input logic exp_opq);
        @(posedge clka); #1;
        req_valid = '0;
        req_valid[ch] = 1'b1;
        req_x[ch*6 +: 6] = 6'(x);
        req_y[ch*6 +: 6] = 6'(y);
        @(negedge clka);
        chk({tag, "_ready"}, 32'(req_ready), 32'(1 << ch));
        @(posedge clka); #1;
        req_valid = '0;
        @(negedge clka);
        chk({tag, "_early"}, 32'(rsp_valid), 32'h0);
        @(negedge clka);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'h1);
        chk({tag, "_ch"},    32'(rsp_ch),    32'(ch));
        chk({tag, "_data"},  32'(rsp_data),  32'(exp_dat));
        chk({tag, "_oob"},   32'(rsp_oob),   32'(exp_oob));
        chk({tag, "_opq"},   32'(rsp_opaque), 32'(exp_opq));
    endtask

    logic exp_key_opq;

    initial begin
        for (int i = 0; i < 1600; i++) dut.u_rom.mem[i] = rom_word(i);
`ifdef SPRITE_ROM_KEY_EN
        exp_key_opq = 1'b0;
`else
        exp_key_opq = 1'b1;
`endif

        // Reset state.
        repeat (2) @(posedge clka);
        do_reset();
        @(negedge clka);
        chk("rst_valid",  32'(rsp_valid),  32'h0);
        chk("rst_ch",     32'(rsp_ch),     32'h0);
        chk("rst_data",   32'(rsp_data),   32'h0);
        chk("rst_oob",    32'(rsp_oob),    32'h0);
        chk("rst_opq",    32'(rsp_opaque), 32'h0);
        chk("idle_ready", 32'(req_ready),  32'h0);

        // ch0 at (3,2) -> address 83.
        single("c0_3_2", 0, 3, 2, rom_word(83), 1'b0, 1'b1);
        @(negedge clka);
        chk("hold_valid", 32'(rsp_valid), 32'h0);
        chk("hold_data",  32'(rsp_data),  32'(rom_word(83)));

        // Both channels held for 4 cycles from a fresh pointer.
        do_reset();
        req_valid = 2'b11;
        req_x = {6'd2, 6'd1};
        req_y = {6'd1, 6'd0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clka);
            if (c < 4) chk("rr_ready", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
            if (c < 2) begin
                chk("rr_early", 32'(rsp_valid), 32'h0);
            end else begin
                chk("rr_valid", 32'(rsp_valid), 32'h1);
                chk("rr_ch",    32'(rsp_ch),    32'((c - 2) % 2));
                chk("rr_data",  32'(rsp_data),  ((c - 2) % 2 == 0) ? 32'(rom_word(1)) : 32'(rom_word(42)));
            end
            @(posedge clka); #1;
            if (c == 3) req_valid = 2'b00;
        end

        // Out-of-range and edge coordinates.
        single("oob_x40",  1, 40, 0,  16'h0,           1'b1, 1'b0);
        single("edge_39",  0, 39, 39, rom_word(1599),  1'b0, 1'b1);
        single("oob_y40",  1, 0,  40, 16'h0,           1'b1, 1'b0);
        single("oob_63",   0, 63, 63, 16'h0,           1'b1, 1'b0);

        // Key colour at address 0.
        single("key_0_0",  0, 0,  0,  16'hF81F,        1'b0, exp_key_opq);

        // Reset one cycle after a grant: response dropped, pointer back to 0.
        @(posedge clka); #1;
        req_valid = 2'b01;
        req_x = {6'd0, 6'd5};
        req_y = {6'd0, 6'd0};
        @(negedge clka);
        chk("mid_ready", 32'(req_ready), 32'h1);
        @(posedge clka); #1;
        rsta      = 1'b1;
        req_valid = 2'b11;
        @(negedge clka);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        @(posedge clka); #1;
        rsta      = 1'b0;
        req_valid = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clka);
            chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
        end
        @(posedge clka); #1;
        req_valid = 2'b11;
        @(negedge clka);
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        @(posedge clka); #1;
        req_valid = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
